// File: rtl/lua_reg_cache.sv
// Register-window cache for the Lua CPU: holds NREGS TValue slots (value + tag) of the
// current frame, fills misses over an Avalon master and writes dirty slots back on flush.
module lua_reg_cache #(
    parameter int NREGS   = 32,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 3,
    parameter int STRIDE  = 8,
    parameter int TAG_OFF = 4,
    localparam int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       base,
    input  logic              rd_req,
    input  logic [IDX_W-1:0]  rd_b_idx,
    input  logic [IDX_W-1:0]  rd_c_idx,
    output logic              rd_ack,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] data_c,
    output logic [TAG_W-1:0]  type_b,
    output logic [TAG_W-1:0]  type_c,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  wr_type,
    output logic              wr_ready,
    input  logic              flush,
    output logic              flush_done,
    input  logic              invalidate,
    output logic              busy,
    output logic [31:0]       mem_address,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       mem_writedata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FILL_VAL   = 3'd1,
        S_FILL_TAG   = 3'd2,
        S_FLUSH_SCAN = 3'd3,
        S_FLUSH_VAL  = 3'd4,
        S_FLUSH_TAG  = 3'd5
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
    logic [DATA_W-1:0]  fill_val_q, fill_val_d;
    logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
    logic [DATA_W-1:0]  val_q [NREGS];
    logic [TAG_W-1:0]   tag_q [NREGS];
    logic [NREGS-1:0]   valid_q;
    logic [NREGS-1:0]   dirty_q;

    logic idle_s, wr_acc_s, fwd_b_s, fwd_c_s, b_ok_s, c_ok_s;
    logic inv_s, fill_commit_s, clean_s;

    function automatic logic [31:0] slot_addr(input logic [31:0] b, input logic [IDX_W-1:0] i,
                                              input logic tag_sel);
        slot_addr = b + (32'(i) * 32'(STRIDE)) + (tag_sel ? 32'(TAG_OFF) : 32'h0000_0000);
    endfunction

    assign idle_s   = (state_q == S_IDLE);
    assign busy     = !idle_s;
    assign wr_ready = idle_s;
    // invalidate outranks a same-cycle write, so the write is dropped with everything else
    assign wr_acc_s = idle_s && wr_en && !invalidate;
    assign fwd_b_s  = wr_acc_s && (wr_idx == rd_b_idx);
    assign fwd_c_s  = wr_acc_s && (wr_idx == rd_c_idx);
    assign b_ok_s   = valid_q[rd_b_idx] || fwd_b_s;
    assign c_ok_s   = valid_q[rd_c_idx] || fwd_c_s;
    assign rd_ack   = idle_s && rd_req && b_ok_s && c_ok_s;
    assign data_b   = rd_ack ? (fwd_b_s ? wr_data : val_q[rd_b_idx]) : '0;
    assign data_c   = rd_ack ? (fwd_c_s ? wr_data : val_q[rd_c_idx]) : '0;
    assign type_b   = rd_ack ? (fwd_b_s ? wr_type : tag_q[rd_b_idx]) : '0;
    assign type_c   = rd_ack ? (fwd_c_s ? wr_type : tag_q[rd_c_idx]) : '0;

    // Next-state, Avalon strobes and storage update controls
    always_comb begin
        state_d       = state_q;
        fill_idx_d    = fill_idx_q;
        fill_val_d    = fill_val_q;
        scan_idx_d    = scan_idx_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 32'h0000_0000;
        mem_writedata = 32'h0000_0000;
        flush_done    = 1'b0;
        inv_s         = 1'b0;
        fill_commit_s = 1'b0;
        clean_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (invalidate) begin
                    inv_s = 1'b1;
                end else if (flush) begin
                    scan_idx_d = '0;
                    state_d    = S_FLUSH_SCAN;
                end else if (rd_req && !b_ok_s) begin
                    fill_idx_d = rd_b_idx;
                    state_d    = S_FILL_VAL;
                end else if (rd_req && !c_ok_s) begin
                    fill_idx_d = rd_c_idx;
                    state_d    = S_FILL_VAL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL_VAL: begin
                mem_read    = 1'b1;
                mem_address = slot_addr(base, fill_idx_q, 1'b0);
                if (!mem_waitrequest) begin
                    fill_val_d = mem_readdata[DATA_W-1:0];
                    state_d    = S_FILL_TAG;
                end else begin
                    state_d = S_FILL_VAL;
                end
            end
            S_FILL_TAG: begin
                mem_read    = 1'b1;
                mem_address = slot_addr(base, fill_idx_q, 1'b1);
                if (!mem_waitrequest) begin
                    fill_commit_s = 1'b1;
                    // chain straight into the C fill so a double miss costs no idle cycle
                    if (rd_req && (rd_c_idx != fill_idx_q) && !valid_q[rd_c_idx]) begin
                        fill_idx_d = rd_c_idx;
                        state_d    = S_FILL_VAL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_FILL_TAG;
                end
            end
            S_FLUSH_SCAN: begin
                if (dirty_q[scan_idx_q]) begin
                    state_d = S_FLUSH_VAL;
                end else if (scan_idx_q == LAST_IDX) begin
                    flush_done = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            S_FLUSH_VAL: begin
                mem_write     = 1'b1;
                mem_address   = slot_addr(base, scan_idx_q, 1'b0);
                mem_writedata = 32'(val_q[scan_idx_q]);
                if (!mem_waitrequest) begin
                    state_d = S_FLUSH_TAG;
                end else begin
                    state_d = S_FLUSH_VAL;
                end
            end
            S_FLUSH_TAG: begin
                mem_write     = 1'b1;
                mem_address   = slot_addr(base, scan_idx_q, 1'b1);
                mem_writedata = 32'(tag_q[scan_idx_q]);
                if (!mem_waitrequest) begin
                    clean_s = 1'b1;
                    if (scan_idx_q == LAST_IDX) begin
                        flush_done = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        scan_idx_d = scan_idx_q + 1'b1;
                        state_d    = S_FLUSH_SCAN;
                    end
                end else begin
                    state_d = S_FLUSH_TAG;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and fill/scan bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fill_idx_q <= '0;
            fill_val_q <= '0;
            scan_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_idx_q <= fill_idx_d;
            fill_val_q <= fill_val_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    // Cached entries with their valid and dirty flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (inv_s) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_acc_s) begin
            val_q[wr_idx]   <= wr_data;
            tag_q[wr_idx]   <= wr_type;
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= 1'b1;
        end else if (fill_commit_s) begin
            val_q[fill_idx_q]   <= fill_val_q;
            tag_q[fill_idx_q]   <= mem_readdata[TAG_W-1:0];
            valid_q[fill_idx_q] <= 1'b1;
            dirty_q[fill_idx_q] <= 1'b0;
        end else if (clean_s) begin
            dirty_q[scan_idx_q] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lua_reg_cache.sv
// Self-checking bench for lua_reg_cache: table of hit/forward vectors plus directed
// miss, flush, ignored-request and reset-during-fill sequences against an Avalon memory model.
module tb_lua_reg_cache;

    logic        clk, rst_n;
    logic [31:0] base;
    logic        rd_req;
    logic [4:0]  rd_b_idx, rd_c_idx;
    logic        rd_ack;
    logic [31:0] data_b, data_c;
    logic [2:0]  type_b, type_c;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    logic [2:0]  wr_type;
    logic        wr_ready, flush, flush_done, invalidate, busy;
    logic [31:0] mem_address, mem_readdata, mem_writedata;
    logic        mem_read, mem_write, mem_waitrequest;

    int errors = 0;
    int checks = 0;
    int wait_cfg = 0;
    int wcnt = 0;
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_wa_q[$];
    logic [31:0] exp_wd_q[$];

    typedef struct {
        logic        we;
        logic [4:0]  wi;
        logic [31:0] wd;
        logic [2:0]  wt;
        logic        rq;
        logic [4:0]  bi, ci;
        logic        ack;
        logic [31:0] db, dc;
        logic [2:0]  tb, tc;
    } vec_t;
    vec_t vecs[7];

    lua_reg_cache dut (
        .clk(clk), .rst_n(rst_n), .base(base),
        .rd_req(rd_req), .rd_b_idx(rd_b_idx), .rd_c_idx(rd_c_idx), .rd_ack(rd_ack),
        .data_b(data_b), .data_c(data_c), .type_b(type_b), .type_c(type_c),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_type(wr_type),
        .wr_ready(wr_ready), .flush(flush), .flush_done(flush_done),
        .invalidate(invalidate), .busy(busy),
        .mem_address(mem_address), .mem_readdata(mem_readdata),
        .mem_writedata(mem_writedata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_waitrequest(mem_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [2:0] ptag(input logic [31:0] a);
        logic [31:0] v;
        v = pat(a);
        return v[2:0];
    endfunction

    assign mem_readdata    = mem_read ? pat(mem_address) : 32'h0000_0000;
    assign mem_waitrequest = (mem_read || mem_write) && (wcnt < wait_cfg);

    always @(posedge clk) begin
        if ((mem_read || mem_write) && mem_waitrequest) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic probe(input logic [4:0] b, input logic [4:0] c, input logic exp, input string name);
        @(negedge clk);
        rd_b_idx = b; rd_c_idx = c; rd_req = 1'b1;
        #1 chk(name, rd_ack, exp);
        #1 rd_req = 1'b0;
    endtask

    task automatic run_read(input logic [4:0] b, input logic [4:0] c, input int w, input int exp_cyc,
                            input bit inject, input logic [31:0] edb, input logic [31:0] edc,
                            input logic [2:0] etb, input logic [2:0] etc);
        int ack_cyc;
        int nrd;
        ack_cyc  = -1;
        nrd      = 0;
        wait_cfg = w;
        @(negedge clk);
        rd_b_idx = b; rd_c_idx = c; rd_req = 1'b1;
        #1;
        for (int k = 0; k < 100; k++) begin
            if (k > 0) begin
                @(negedge clk);
                flush = inject && (k == 1); wr_en = inject && (k == 1);
                invalidate = inject && (k == 1); wr_idx = 5'd11; wr_data = 32'h7777_7777; wr_type = 3'd5;
                #1;
            end
            if (rd_ack) begin
                ack_cyc = k;
                break;
            end
            if (k > 0) begin
                chk("busy_in_fill", busy, 1'b1);
                chk("wr_ready_in_fill", wr_ready, 1'b0);
            end
            chk("no_write_in_fill", mem_write, 1'b0);
            if (mem_read) begin
                if (nrd < exp_rd_q.size()) chk("rd_addr", mem_address, exp_rd_q[nrd]);
                else chk("extra_read", mem_address, 32'hFFFF_FFFF);
                if (!mem_waitrequest) nrd++;
            end
        end
        chk("ack_cycle", ack_cyc, exp_cyc);
        chk("n_reads", nrd, exp_rd_q.size());
        if (ack_cyc >= 0) begin
            chk("data_b", data_b, edb);
            chk("data_c", data_c, edc);
            chk("type_b", type_b, etb);
            chk("type_c", type_c, etc);
        end
        rd_req = 1'b0; flush = 1'b0; wr_en = 1'b0; invalidate = 1'b0;
        exp_rd_q.delete();
    endtask

    task automatic run_flush(input int exp_cyc);
        int done_cyc;
        int nwr;
        done_cyc = -1;
        nwr      = 0;
        @(negedge clk);
        flush = 1'b1;
        #1;
        for (int k = 0; k < 300; k++) begin
            if (k > 0) begin
                @(negedge clk);
                flush = 1'b0;
                #1;
            end
            if (mem_write) begin
                chk("rw_exclusive", mem_read, 1'b0);
                if (nwr < exp_wa_q.size()) begin
                    chk("wr_addr", mem_address, exp_wa_q[nwr]);
                    chk("wr_data", mem_writedata, exp_wd_q[nwr]);
                end else begin
                    chk("extra_write", mem_address, 32'hFFFF_FFFF);
                end
                if (!mem_waitrequest) nwr++;
            end
            if (flush_done) begin
                done_cyc = k;
                break;
            end
        end
        chk("flush_done_cycle", done_cyc, exp_cyc);
        chk("n_writes", nwr, exp_wa_q.size());
        @(negedge clk);
        #1;
        chk("flush_done_one_cycle", flush_done, 1'b0);
        chk("idle_after_flush", busy, 1'b0);
        exp_wa_q.delete();
        exp_wd_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; base = 32'h0000_1000; rd_req = 1'b0; rd_b_idx = '0; rd_c_idx = '0;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_type = '0; flush = 1'b0; invalidate = 1'b0;

        vecs[0] = '{1'b1, 5'd3, 32'h1234_5678, 3'd1, 1'b1, 5'd3, 5'd3, 1'b1, 32'h1234_5678, 32'h1234_5678, 3'd1, 3'd1};
        vecs[1] = '{1'b0, 5'd0, 32'h0000_0000, 3'd0, 1'b1, 5'd3, 5'd3, 1'b1, 32'h1234_5678, 32'h1234_5678, 3'd1, 3'd1};
        vecs[2] = '{1'b1, 5'd5, 32'hCAFE_F00D, 3'd4, 1'b1, 5'd3, 5'd5, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 3'd1, 3'd4};
        vecs[3] = '{1'b1, 5'd7, 32'h0000_DEAD, 3'd2, 1'b1, 5'd7, 5'd3, 1'b1, 32'h0000_DEAD, 32'h1234_5678, 3'd2, 3'd1};
        vecs[4] = '{1'b1, 5'd3, 32'h0BAD_BEEF, 3'd6, 1'b1, 5'd3, 5'd5, 1'b1, 32'h0BAD_BEEF, 32'hCAFE_F00D, 3'd6, 3'd4};
        vecs[5] = '{1'b0, 5'd0, 32'h0000_0000, 3'd0, 1'b1, 5'd3, 5'd7, 1'b1, 32'h0BAD_BEEF, 32'h0000_DEAD, 3'd6, 3'd2};
        vecs[6] = '{1'b1, 5'd9, 32'h1111_1111, 3'd3, 1'b0, 5'd9, 5'd9, 1'b0, 32'h0000_0000, 32'h0000_0000, 3'd0, 3'd0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_writedata", mem_writedata, 32'h0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_rd_ack", rd_ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            wr_en = vecs[i].we; wr_idx = vecs[i].wi; wr_data = vecs[i].wd; wr_type = vecs[i].wt;
            rd_req = vecs[i].rq; rd_b_idx = vecs[i].bi; rd_c_idx = vecs[i].ci;
            #1;
            chk($sformatf("vec%0d_ack", i), rd_ack, vecs[i].ack);
            if (vecs[i].ack) begin
                chk($sformatf("vec%0d_data_b", i), data_b, vecs[i].db);
                chk($sformatf("vec%0d_data_c", i), data_c, vecs[i].dc);
                chk($sformatf("vec%0d_type_b", i), type_b, vecs[i].tb);
                chk($sformatf("vec%0d_type_c", i), type_c, vecs[i].tc);
            end
        end
        @(negedge clk);
        wr_en = 1'b0; rd_req = 1'b0;

        // single miss on B, zero wait
        exp_rd_q.push_back(32'h0000_1010); exp_rd_q.push_back(32'h0000_1014);
        run_read(5'd2, 5'd5, 0, 3, 1'b0, pat(32'h1010), 32'hCAFE_F00D, ptag(32'h1014), 3'd4);
        // single miss, two wait states per read
        exp_rd_q.push_back(32'h0000_1030); exp_rd_q.push_back(32'h0000_1034);
        run_read(5'd6, 5'd5, 2, 7, 1'b0, pat(32'h1030), 32'hCAFE_F00D, ptag(32'h1034), 3'd4);
        // double miss
        exp_rd_q.push_back(32'h0000_10A0); exp_rd_q.push_back(32'h0000_10A4);
        exp_rd_q.push_back(32'h0000_10A8); exp_rd_q.push_back(32'h0000_10AC);
        run_read(5'd20, 5'd21, 0, 5, 1'b0, pat(32'h10A0), pat(32'h10A8), ptag(32'h10A4), ptag(32'h10AC));
        // same index on both operands: one fill only
        exp_rd_q.push_back(32'h0000_10B0); exp_rd_q.push_back(32'h0000_10B4);
        run_read(5'd22, 5'd22, 0, 3, 1'b0, pat(32'h10B0), pat(32'h10B0), ptag(32'h10B4), ptag(32'h10B4));
        // previously filled entries now hit
        run_read(5'd2, 5'd6, 0, 0, 1'b0, pat(32'h1010), pat(32'h1030), ptag(32'h1014), ptag(32'h1034));

        // flush, write and invalidate during FILL_VAL are ignored
        exp_rd_q.push_back(32'h0000_1050); exp_rd_q.push_back(32'h0000_1054);
        run_read(5'd10, 5'd3, 2, 7, 1'b1, pat(32'h1050), 32'h0BAD_BEEF, ptag(32'h1054), 3'd6);
        probe(5'd11, 5'd11, 1'b0, "ignored_write_not_valid");
        probe(5'd3, 5'd20, 1'b1, "ignored_invalidate_keeps_valid");

        // invalidate, then dirty entries 0 and 31 with wrapping base
        @(negedge clk); invalidate = 1'b1;
        @(negedge clk); invalidate = 1'b0;
        probe(5'd3, 5'd5, 1'b0, "invalidate_clears");
        @(negedge clk); wr_en = 1'b1; wr_idx = 5'd0; wr_data = 32'hA0A0_A0A0; wr_type = 3'd5;
        @(negedge clk); wr_idx = 5'd31; wr_data = 32'h3131_3131; wr_type = 3'd7;
        @(negedge clk); wr_en = 1'b0; base = 32'hFFFF_FFF8;
        exp_wa_q.push_back(32'hFFFF_FFF8); exp_wd_q.push_back(32'hA0A0_A0A0);
        exp_wa_q.push_back(32'hFFFF_FFFC); exp_wd_q.push_back(32'h0000_0005);
        exp_wa_q.push_back(32'h0000_00F0); exp_wd_q.push_back(32'h3131_3131);
        exp_wa_q.push_back(32'h0000_00F4); exp_wd_q.push_back(32'h0000_0007);
        wait_cfg = 0;
        run_flush(36);
        run_flush(32);
        probe(5'd0, 5'd31, 1'b1, "flush_keeps_valid");

        // reset in the middle of FILL_TAG
        @(negedge clk); base = 32'h0000_1000;
        @(negedge clk); rd_b_idx = 5'd12; rd_c_idx = 5'd0; rd_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("fill_tag_read", mem_read, 1'b1);
        chk("fill_tag_addr", mem_address, 32'h0000_1064);
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_read", mem_read, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_addr", mem_address, 32'h0);
        rd_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        probe(5'd12, 5'd12, 1'b0, "rst_fill_discarded");
        probe(5'd0, 5'd31, 1'b0, "rst_valid_cleared");
        probe(5'd2, 5'd2, 1'b0, "rst_valid_cleared_2");
        chk("rst_wr_ready", wr_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
